// File: rtl/mult_div_unit_if.sv
// Bus between the datapath controller and the multiply/divide unit.
//
// Handshake: the controller may raise Start (with Op, SrcA, SrcB) or
// WrHi/WrLo (with WrData) for one cycle whenever Busy is low. The unit
// samples them on the next rising edge and ignores them while Busy is
// high. Done pulses high for exactly one cycle when Hi/Lo hold the
// result. DivZero pulses together with Done for a zero divisor. A new
// Start may be presented in the Done cycle. State mirrors the unit's
// FSM for observation only.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             WrHi;
  logic             WrLo;
  logic [WIDTH-1:0] WrData;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic [1:0]       State;

  modport master (
    output Start, Op, SrcA, SrcB, WrHi, WrLo, WrData,
    input  Busy, Done, DivZero, Hi, Lo, State
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, WrHi, WrLo, WrData,
    output Busy, Done, DivZero, Hi, Lo, State
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MIPS multiply/divide unit. Shift-add multiply and restoring
// divide, one bit per clock, on operand magnitudes; signs are applied in a
// final fix-up cycle. Results land in the HI/LO registers.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_div;     // 1: divide, 0: multiply
  logic               neg_q;      // negate product / quotient
  logic               neg_r;      // negate remainder
  logic               div_zero;   // zero divisor seen at launch
  logic [WIDTH-1:0]   operand;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // mult: {partial, multiplier}; div: {rem, quotient}

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.State = state;

  // Operand magnitudes for launch; unsigned ops pass through unchanged.
  always_comb begin
    signed_op = ~bus.Op[0];
    a_abs     = (signed_op && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    b_abs     = (signed_op && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, operand};
    acc_next  = acc;
    if (op_div) begin
      if (!div_diff[WIDTH+1]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the unsigned result.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered Busy/Done/DivZero and the HI/LO registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
      operand     <= '0;
      acc         <= '0;
      bus.Busy    <= 1'b0;
      bus.Done    <= 1'b0;
      bus.DivZero <= 1'b0;
      bus.Hi      <= '0;
      bus.Lo      <= '0;
    end else begin
      bus.Done    <= 1'b0;
      bus.DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.WrHi) bus.Hi <= bus.WrData;
          if (bus.WrLo) bus.Lo <= bus.WrData;
          if (bus.Start) begin
            op_div   <= bus.Op[1];
            neg_q    <= signed_op & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            neg_r    <= signed_op & bus.SrcA[WIDTH-1];
            operand  <= bus.Op[1] ? b_abs : a_abs;
            acc      <= {{WIDTH{1'b0}}, (bus.Op[1] ? a_abs : b_abs)};
            cnt      <= '0;
            bus.Busy <= 1'b1;
            // A zero divisor skips the iterations entirely.
            if (bus.Op[1] && (bus.SrcB == '0)) begin
              div_zero <= 1'b1;
              state    <= FIX;
            end else begin
              div_zero <= 1'b0;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (div_zero) begin
            bus.DivZero <= 1'b1;
          end else if (op_div) begin
            bus.Hi <= rem_fix;
            bus.Lo <= quo_fix;
          end else begin
            {bus.Hi, bus.Lo} <= prod_fix;
          end
          bus.Done <= 1'b1;
          bus.Busy <= 1'b0;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: scoreboard of expected {DivZero, Hi, Lo}
// pushed at launch and compared on every Done pulse, plus latency,
// Busy, ignore-while-busy and asynchronous reset checks.
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam int EW    = 2 * WIDTH + 1;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;

  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] hi_m;
  logic [WIDTH-1:0] lo_m;
  int               e0;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: returns {div_zero, hi, lo}.
  function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] hi,
                                          input logic [WIDTH-1:0] lo);
    logic signed [2*WIDTH-1:0] sa, sb, sp, sq, sr;
    logic [2*WIDTH-1:0]        ua, ub;
    sa = {{WIDTH{a[WIDTH-1]}}, a};
    sb = {{WIDTH{b[WIDTH-1]}}, b};
    ua = {{WIDTH{1'b0}}, a};
    ub = {{WIDTH{1'b0}}, b};
    case (op)
      OP_MULT: begin
        sp = sa * sb;
        return {1'b0, sp};
      end
      OP_MULTU: return {1'b0, ua * ub};
      OP_DIV: begin
        if (b == '0) return {1'b1, hi, lo};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr[WIDTH-1:0], sq[WIDTH-1:0]};
      end
      default: begin
        if (b == '0) return {1'b1, hi, lo};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  // Every Done pulse pops one expectation; DivZero must never appear alone.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("result", {bus.DivZero, bus.Hi, bus.Lo}, exp_q.pop_front());
        end
      end else if (bus.DivZero) begin
        check("divzero_without_done", 1, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge; presents the request for the next edge (E0).
  task automatic launch(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic whi, input logic wlo, input logic [WIDTH-1:0] wdata);
    logic [EW-1:0] e;
    bus.Start  = 1'b1;
    bus.Op     = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.WrHi   = whi;
    bus.WrLo   = wlo;
    bus.WrData = wdata;
    if (whi) hi_m = wdata;
    if (wlo) lo_m = wdata;
    e = model(op, a, b, hi_m, lo_m);
    exp_q.push_back(e);
    {hi_m, lo_m} = e[2*WIDTH-1:0];
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.Start = 1'b0;
    bus.WrHi  = 1'b0;
    bus.WrLo  = 1'b0;
  endtask

  // Waits (bounded) for Done; checks edges since E0 and that Busy stayed high.
  task automatic wait_done(input string tag, input int exp_lat);
    int busy_lo;
    int guard;
    busy_lo = 0;
    guard   = 0;
    while (guard < 200) begin
      if (!bus.Busy) busy_lo++;
      @(posedge clk);
      #1;
      guard++;
      if (bus.Done) break;
    end
    if (!bus.Done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_latency"}, EW'(cyc - e0), EW'(exp_lat));
    check({tag, "_busy_held"}, EW'(busy_lo), 0);
    check({tag, "_busy_off"}, EW'(bus.Busy), 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    launch(op, a, b, 1'b0, 1'b0, '0);
    wait_done(tag, (op[1] && b == '0) ? 1 : WIDTH + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] lo_before;
    logic [1:0]       rop;
    logic [WIDTH-1:0] ra, rb;
    int               done_cnt;

    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    hi_m  = '0;
    lo_m  = '0;
    e0    = 0;
    rst   = 1'b1;
    bus.Start  = 1'b0;
    bus.Op     = '0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    bus.WrHi   = 1'b0;
    bus.WrLo   = 1'b0;
    bus.WrData = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", EW'(bus.Busy), 0);
    check("rst_done", EW'(bus.Done), 0);
    check("rst_divzero", EW'(bus.DivZero), 0);
    check("rst_hi", EW'(bus.Hi), 0);
    check("rst_lo", EW'(bus.Lo), 0);

    // Signed/unsigned multiply and divide corner values.
    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_m1xm1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE);

    // MTHI + MTLO together, then divide by zero keeps them.
    bus.WrHi   = 1'b1;
    bus.WrLo   = 1'b1;
    bus.WrData = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.WrHi = 1'b0;
    bus.WrLo = 1'b0;
    hi_m = 32'h1234_5678;
    lo_m = 32'h1234_5678;
    check("mthi", EW'(bus.Hi), EW'(32'h1234_5678));
    check("mtlo", EW'(bus.Lo), EW'(32'h1234_5678));
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0);
    run_op("div_by0", OP_DIV, 32'hFFFF_FF00, 32'd0);

    // Write in the same cycle as a launch: write lands, result overwrites later.
    launch(OP_DIVU, 32'd9, 32'd0, 1'b1, 1'b0, 32'hAAAA_5555);
    wait_done("wr_with_dz", 1);
    launch(OP_MULTU, 32'd7, 32'd6, 1'b0, 1'b1, 32'hDEAD_BEEF);
    wait_done("wr_with_mul", WIDTH + 1);

    // Start and WrLo while busy are both ignored; then back-to-back launch.
    lo_before = bus.Lo;
    launch(OP_MULTU, 32'd3, 32'd4, 1'b0, 1'b0, '0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    bus.Start  = 1'b1;
    bus.Op     = OP_DIV;
    bus.SrcA   = 32'd1000;
    bus.SrcB   = 32'd3;
    bus.WrLo   = 1'b1;
    bus.WrData = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.WrLo  = 1'b0;
    check("busy_wrlo_ignored", EW'(bus.Lo), EW'(lo_before));
    check("busy_start_ignored", EW'(bus.Busy), 1);
    wait_done("ignore_while_busy", WIDTH + 1);
    run_op("back_to_back", OP_DIV, 32'hFFFF_FC18, 32'd7);

    // Asynchronous reset in the middle of a divide.
    launch(OP_DIVU, 32'd123456, 32'd7, 1'b0, 1'b0, '0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    hi_m = '0;
    lo_m = '0;
    #1;
    check("arst_busy", EW'(bus.Busy), 0);
    check("arst_done", EW'(bus.Done), 0);
    check("arst_divzero", EW'(bus.DivZero), 0);
    check("arst_hi", EW'(bus.Hi), 0);
    check("arst_lo", EW'(bus.Lo), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.Done) done_cnt++;
    end
    check("arst_no_done", EW'(done_cnt), 0);
    run_op("after_reset", OP_MULT, 32'h8000_0000, 32'h8000_0000);

    // Random operations, some with tiny or zero divisors.
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom_range(0, 9)) : $urandom;
      run_op("random", rop, ra, rb);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", EW'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
